// File: rtl/controller_input_conditioner_if.sv
// Bus between the controller manager/processor and one input conditioner instance.
// rawInput is sampled every cycle with no valid/ready and no backpressure. readStrobe is a single-cycle pulse.
interface controller_input_conditioner_if;
  logic [31:0] rawInput;
  logic        readStrobe;
  logic [31:0] condInput;
  logic [31:0] pressEvents;
  logic        anyPress;

  modport master (
    output rawInput, readStrobe,
    input  condInput, pressEvents, anyPress
  );

  modport slave (
    input  rawInput, readStrobe,
    output condInput, pressEvents, anyPress
  );
endinterface

// File: rtl/controller_input_conditioner.sv
// Per-player controller word conditioner: synchroniser, button debounce, stick hysteresis, sticky press events.
// Optional macro CONDITIONER_RELEASE_EDGE_EN adds release-edge events in pressEvents[9:0].
module controller_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STICK_DEADBAND  = 2
) (
  input logic fastClock,
  input logic reset,
  controller_input_conditioner_if.slave bus
);

  localparam logic [15:0] CNT_MAX  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]  DEADBAND = 5'(STICK_DEADBAND);

  logic [9:0]       btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic             fac_s1_q, fac_s1_d, fac_s2_q, fac_s2_d;
  logic [3:0]       x_s1_q, x_s1_d, x_s2_q, x_s2_d;
  logic [3:0]       y_s1_q, y_s1_d, y_s2_q, y_s2_d;
  logic [9:0]       stable_q, stable_d;
  logic [9:0][15:0] cnt_q, cnt_d;
  logic [3:0]       x_q, x_d, y_q, y_d;
  logic [9:0]       press_q, press_d;
  logic [9:0]       rise;
  logic [9:0]       rel_bits;
  logic             unused_raw_bits;

  assign unused_raw_bits = ^{bus.rawInput[31:27], bus.rawInput[11:8], bus.rawInput[3:0]};

  // Extremes always pass so full tilt is never held back by the deadband.
  function automatic logic [3:0] hyst(input logic [3:0] s, input logic [3:0] cur);
    logic signed [4:0] diff;
    logic [4:0]        mag;
    diff = $signed({1'b0, s}) - $signed({1'b0, cur});
    mag  = diff[4] ? 5'(-diff) : 5'(diff);
    if (mag >= DEADBAND || s == 4'h0 || s == 4'hF) return s;
    return cur;
  endfunction

  always_comb begin
    btn_s1_d = bus.rawInput[25:16];
    btn_s2_d = btn_s1_q;
    fac_s1_d = bus.rawInput[26];
    fac_s2_d = fac_s1_q;
    x_s1_d   = bus.rawInput[7:4];
    x_s2_d   = x_s1_q;
    y_s1_d   = bus.rawInput[15:12];
    y_s2_d   = y_s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 10; i++) begin
      if (btn_s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = btn_s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
    x_d     = hyst(x_s2_q, x_q);
    y_d     = hyst(y_s2_q, y_q);
    rise    = stable_d & ~stable_q;
    // A rise in the same cycle as the clear strobe must survive.
    press_d = (bus.readStrobe ? 10'b0 : press_q) | rise;
  end

  always_ff @(posedge fastClock or posedge reset) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      fac_s1_q <= 1'b1;
      fac_s2_q <= 1'b1;
      x_s1_q   <= '0;
      x_s2_q   <= '0;
      y_s1_q   <= '0;
      y_s2_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      press_q  <= '0;
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      fac_s1_q <= fac_s1_d;
      fac_s2_q <= fac_s2_d;
      x_s1_q   <= x_s1_d;
      x_s2_q   <= x_s2_d;
      y_s1_q   <= y_s1_d;
      y_s2_q   <= y_s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      press_q  <= press_d;
    end
  end

`ifdef CONDITIONER_RELEASE_EDGE_EN
  logic [9:0] rel_q, rel_d;

  always_comb begin
    rel_d = (bus.readStrobe ? 10'b0 : rel_q) | (stable_q & ~stable_d);
  end

  always_ff @(posedge fastClock or posedge reset) begin
    if (reset) rel_q <= '0;
    else       rel_q <= rel_d;
  end

  assign rel_bits = rel_q;
`else
  assign rel_bits = '0;
`endif

  assign bus.condInput   = {5'b0, fac_s2_q, stable_q, y_q, 4'b0, x_q, 4'b0};
  assign bus.pressEvents = {6'b0, press_q, 6'b0, rel_bits};
  assign bus.anyPress    = |press_q | |rel_bits;

endmodule
